// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-side memory responder: access-size
// encodings, MMIO addresses, FSM states and the lane/extend helpers.
package LOAD_STORE_FNS;

    typedef enum logic [2:0] {
        BYTE   = 3'b000,
        HALF   = 3'b001,
        WORD   = 3'b010,
        BYTE_U = 3'b100,
        HALF_U = 3'b101
    } funct3_t;

    localparam logic [31:0] OUTPORT_ADDR = 32'hfffc;
    localparam logic [31:0] INPORT_ADDR  = 32'hfff8;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        RESP
    } dmem_state_t;

    // Byte lanes touched by a store of the given size at the given offset.
    function automatic logic [3:0] lane_enable(input logic [2:0] funct3, input logic [1:0] offset);
        logic [3:0] en;
        case (funct3)
            BYTE:    en = 4'b0001 << offset;
            HALF:    en = offset[1] ? 4'b1100 : 4'b0011;
            WORD:    en = 4'b1111;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

    // Right-aligned store data copied onto every lane it could land in.
    function automatic logic [31:0] store_replicate(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] rep;
        case (funct3)
            BYTE:    rep = {4{wdata[7:0]}};
            HALF:    rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    // Pick the addressed lane out of a word and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] offset,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (offset)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            BYTE:    r = {{24{b[7]}}, b};
            HALF:    r = {{16{h[15]}}, h};
            WORD:    r = word;
            BYTE_U:  r = {24'h0, b};
            HALF_U:  r = {16'h0, h};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_ram_be.sv
// DEPTH x 32 synchronous-read RAM with per-byte write enables. Each byte
// lane is its own array so the tools map it cleanly onto block RAM; a read
// of an address being written returns the old contents.
module dmem_ram_be #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     re,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            // Byte-lane write plus registered read (old data on collision).
            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[addr] <= wdata[gi*8 +: 8];
                end
                if (re) begin
                    rd_byte_reg <= mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data memory responder: terminates core loads/stores against a word RAM,
// an output port register and a synchronized input port, one request at a
// time with valid/ready handshakes on both request and response.
module dmem_responder
    import LOAD_STORE_FNS::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] RESET_OUT = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [31:0] inport,
    output logic [31:0] outport
);

    localparam int AW = $clog2(DEPTH);

    dmem_state_t state_reg;
    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_rdata_reg;
    logic        rsp_err_reg;
    logic [31:0] outport_reg;
    logic [31:0] inport_meta_reg;
    logic [31:0] inport_sync_reg;
    logic [2:0]  ld_funct3_reg;
    logic [1:0]  ld_offset_reg;

    logic        accept;
    logic        funct3_ok;
    logic        misaligned;
    logic        hit_ram;
    logic        hit_out;
    logic        hit_in;
    logic        req_err;
    logic [3:0]  lane_en;
    logic [31:0] wdata_rep;
    logic [31:0] outport_merged;
    logic [31:0] mmio_rdata;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;

    // Request decode: legality, region and lane selection.
    assign accept     = req_valid && req_ready_reg;
    assign funct3_ok  = req_we ? (req_funct3 inside {BYTE, HALF, WORD})
                               : (req_funct3 inside {BYTE, HALF, WORD, BYTE_U, HALF_U});
    assign misaligned = ((req_funct3 == HALF || req_funct3 == HALF_U) && req_addr[0])
                     || (req_funct3 == WORD && req_addr[1:0] != 2'b00);
    assign hit_ram    = (req_addr[31:AW+2] == '0);
    assign hit_out    = (req_addr[31:2] == OUTPORT_ADDR[31:2]);
    assign hit_in     = (req_addr[31:2] == INPORT_ADDR[31:2]);
    assign req_err    = !funct3_ok || misaligned || !(hit_ram || hit_out || hit_in);
    assign lane_en    = lane_enable(req_funct3, req_addr[1:0]);
    assign wdata_rep  = store_replicate(req_funct3, req_wdata);
    assign mmio_rdata = load_extend(req_funct3, req_addr[1:0], hit_out ? outport_reg : inport_sync_reg);

    // Lane merge of store data into the output port register.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_out_lane
            assign outport_merged[gi*8 +: 8] = lane_en[gi] ? wdata_rep[gi*8 +: 8] : outport_reg[gi*8 +: 8];
        end
    endgenerate

    // RAM strobes only fire for a legal access accepted into the RAM range.
    assign ram_we = (accept && req_we && !req_err && hit_ram) ? lane_en : 4'b0000;
    assign ram_re = accept && !req_we && !req_err && hit_ram;

    dmem_ram_be #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (req_addr[AW+1:2]),
        .wdata (wdata_rep),
        .rdata (ram_rdata)
    );

    // Two-flop synchronizer for the asynchronous board input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inport_meta_reg <= 32'h0;
            inport_sync_reg <= 32'h0;
        end else begin
            inport_meta_reg <= inport;
            inport_sync_reg <= inport_meta_reg;
        end
    end

    // Request/response FSM with registered handshake outputs and outport.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
            outport_reg   <= RESET_OUT;
            ld_funct3_reg <= 3'b000;
            ld_offset_reg <= 2'b00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        req_ready_reg <= 1'b0;
                        if (ram_re) begin
                            state_reg     <= RD;
                            ld_funct3_reg <= req_funct3;
                            ld_offset_reg <= req_addr[1:0];
                        end else begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= req_err;
                            rsp_rdata_reg <= (req_err || req_we) ? 32'h0 : mmio_rdata;
                            if (req_we && !req_err && hit_out) begin
                                outport_reg <= outport_merged;
                            end
                        end
                    end
                end
                RD: begin
                    state_reg     <= RESP;
                    rsp_valid_reg <= 1'b1;
                    rsp_err_reg   <= 1'b0;
                    rsp_rdata_reg <= load_extend(ld_funct3_reg, ld_offset_reg, ram_rdata);
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        req_ready_reg <= 1'b1;
                        rsp_valid_reg <= 1'b0;
                        rsp_rdata_reg <= 32'h0;
                        rsp_err_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign outport   = outport_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-level
// reference model of the RAM and the two MMIO words.
module tb_dmem_responder;

    localparam int          DEPTH     = 1024;
    localparam logic [31:0] RESET_OUT = 32'h0000_5a5a;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] inport = 32'h0;
    logic [31:0] outport;

    int check_cnt = 0;
    int error_cnt = 0;

    logic [31:0] model_ram [DEPTH];
    logic [31:0] model_out;
    logic [31:0] model_in;

    dmem_responder #(
        .DEPTH     (DEPTH),
        .RESET_OUT (RESET_OUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .inport     (inport),
        .outport    (outport)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: decode size/sign/region from plain rules, move bytes one by one.
    task automatic model_access(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic err, output int lat);
        int size;
        bit sgn;
        int region;
        int off;
        logic [31:0] word;
        logic [31:0] val;
        size = 0;
        sgn  = 0;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: begin size = 4; sgn = 0; end
            3'd4: begin size = 1; sgn = 0; end
            3'd5: begin size = 2; sgn = 0; end
            default: size = 0;
        endcase
        if (addr < DEPTH * 4)                            region = 0;
        else if (addr >= 32'hfffc && addr <= 32'hffff)   region = 1;
        else if (addr >= 32'hfff8 && addr <= 32'hfffb)   region = 2;
        else                                             region = 3;
        off = int'(addr % 4);
        rd  = 32'h0;
        err = (size == 0) || (we && f3 > 3'd2) || (addr % size != 0) || (region == 3);
        lat = 1;
        if (err) return;
        case (region)
            0:       word = model_ram[addr / 4];
            1:       word = model_out;
            default: word = model_in;
        endcase
        if (we) begin
            for (int i = 0; i < size; i++) word[(off + i) * 8 +: 8] = wd[i * 8 +: 8];
            if (region == 0) model_ram[addr / 4] = word;
            if (region == 1) model_out = word;
        end else begin
            val = 32'h0;
            for (int i = 0; i < size; i++) val[i * 8 +: 8] = word[(off + i) * 8 +: 8];
            if (sgn && val[size * 8 - 1]) val = val | (32'hffff_ffff << (size * 8));
            rd = val;
            if (region == 0) lat = 2;
        end
    endtask

    // Drive one request from a negedge and collect its response; returns at a negedge.
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic err, output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("req_ready_busy", {31'h0, req_ready}, 32'h0);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = -1;
        rd  = rsp_rdata;
        err = rsp_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_txn(input string tag, input bit we, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic        got_err;
        int          got_lat;
        model_access(we, addr, f3, wd, exp_rd, exp_err, exp_lat);
        do_req(we, addr, f3, wd, rd, got_err, got_lat);
        $display("TXN %s we=%0d addr=%h f3=%0d wdata=%h rdata=%h err=%0d lat=%0d outport=%h",
                 tag, we, addr, f3, wd, rd, got_err, got_lat, outport);
        check_eq({tag, "_rdata"}, rd, exp_rd);
        check_eq({tag, "_err"}, {31'h0, got_err}, {31'h0, exp_err});
        check_eq({tag, "_lat"}, 32'(got_lat), 32'(exp_lat));
        check_eq({tag, "_outport"}, outport, model_out);
    endtask

    task automatic set_inport(input logic [31:0] v);
        inport = v;
        repeat (3) @(negedge clk);
        model_in = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout global time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] held;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          n;
        int          kind;
        logic [31:0] addr;
        logic [31:0] unmapped [5];

        unmapped[0] = 32'h0000_1000;
        unmapped[1] = 32'h0000_8000;
        unmapped[2] = 32'h0000_fff4;
        unmapped[3] = 32'h0001_0000;
        unmapped[4] = 32'hffff_fffc;

        model_out = RESET_OUT;
        model_in  = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        check_eq("rst_outport", outport, RESET_OUT);
        rst_n = 1'b1;
        @(negedge clk);

        // Prefill the RAM words used below so no load reads uninitialised data.
        for (int i = 0; i < 16; i++) run_txn("fill", 1'b1, 32'(i * 4), 3'd2, $urandom, rd);
        run_txn("fill_top", 1'b1, 32'(DEPTH * 4 - 4), 3'd2, 32'hcafe_f00d, rd);
        run_txn("ld_top", 1'b0, 32'(DEPTH * 4 - 4), 3'd2, 32'h0, rd);
        check_eq("ld_top_const", rd, 32'hcafe_f00d);

        // Word store/load and sub-word extension.
        run_txn("st_word", 1'b1, 32'h10, 3'd2, 32'hdeadbeef, rd);
        run_txn("ld_word", 1'b0, 32'h10, 3'd2, 32'h0, rd);
        check_eq("ld_word_const", rd, 32'hdeadbeef);
        run_txn("st_byte", 1'b1, 32'h13, 3'd0, 32'h80, rd);
        run_txn("ld_byte", 1'b0, 32'h13, 3'd0, 32'h0, rd);
        check_eq("ld_byte_const", rd, 32'hffffff80);
        run_txn("ld_byteu", 1'b0, 32'h13, 3'd4, 32'h0, rd);
        check_eq("ld_byteu_const", rd, 32'h00000080);
        run_txn("ld_word2", 1'b0, 32'h10, 3'd2, 32'h0, rd);
        check_eq("ld_word2_const", rd, 32'h80adbeef);
        run_txn("ld_half", 1'b0, 32'h10, 3'd1, 32'h0, rd);
        check_eq("ld_half_const", rd, 32'hffffbeef);
        run_txn("ld_halfu", 1'b0, 32'h12, 3'd5, 32'h0, rd);
        check_eq("ld_halfu_const", rd, 32'h000080ad);

        // Output port half store and read-back.
        run_txn("st_out_half", 1'b1, 32'hfffe, 3'd1, 32'h1234, rd);
        check_eq("outport_merge", outport, {16'h1234, RESET_OUT[15:0]});
        run_txn("ld_out", 1'b0, 32'hfffc, 3'd2, 32'h0, rd);
        check_eq("ld_out_const", rd, {16'h1234, RESET_OUT[15:0]});

        // Input port through the synchronizer; stores to it are ignored.
        set_inport(32'h0000a5a5);
        run_txn("ld_in", 1'b0, 32'hfff8, 3'd2, 32'h0, rd);
        check_eq("ld_in_const", rd, 32'h0000a5a5);
        run_txn("st_in", 1'b1, 32'hfff8, 3'd2, 32'hffffffff, rd);
        run_txn("ld_in_b", 1'b0, 32'hfff9, 3'd0, 32'h0, rd);
        check_eq("ld_in_b_const", rd, 32'hffffffa5);

        // Error cases leave RAM and outport untouched.
        run_txn("err_ld_half", 1'b0, 32'h11, 3'd1, 32'h0, rd);
        run_txn("err_st_word", 1'b1, 32'h12, 3'd2, 32'h11111111, rd);
        run_txn("err_f3_011", 1'b0, 32'h10, 3'd3, 32'h0, rd);
        run_txn("err_st_byteu", 1'b1, 32'h10, 3'd4, 32'h22222222, rd);
        run_txn("err_ld_8000", 1'b0, 32'h8000, 3'd2, 32'h0, rd);
        run_txn("err_st_8000", 1'b1, 32'h8000, 3'd2, 32'h33333333, rd);
        run_txn("err_st_out", 1'b1, 32'hfffd, 3'd1, 32'h4444, rd);
        run_txn("post_err_ram", 1'b0, 32'h10, 3'd2, 32'h0, rd);
        check_eq("post_err_ram_const", rd, 32'h80adbeef);
        run_txn("post_err_out", 1'b0, 32'hfffc, 3'd2, 32'h0, rd);
        check_eq("post_err_out_const", rd, {16'h1234, RESET_OUT[15:0]});

        // Randomized mix of sizes, regions, directions and alignments.
        set_inport($urandom);
        for (int t = 0; t < 150; t++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0, 1, 2: addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                3:       addr = 32'hfffc + 32'($urandom_range(0, 3));
                4:       addr = 32'hfff8 + 32'($urandom_range(0, 3));
                default: addr = unmapped[$urandom_range(0, 4)] + 32'($urandom_range(0, 3));
            endcase
            run_txn("rand", 1'($urandom_range(0, 1)), addr, 3'($urandom_range(0, 7)), $urandom, rd);
        end

        // Backpressure: response must hold while rsp_ready stays low.
        model_access(1'b0, 32'h10, 3'd2, 32'h0, exp_rd, exp_err, exp_lat);
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h10;
        req_funct3 = 3'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        held = rsp_rdata;
        check_eq("bp_rdata", held, exp_rd);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_hold_valid", {31'h0, rsp_valid}, 32'h1);
            check_eq("bp_hold_rdata", rsp_rdata, exp_rd);
            check_eq("bp_hold_ready", {31'h0, req_ready}, 32'h0);
        end
        $display("TXN backpressure addr=%h rdata=%h held=5", 32'h10, held);

        // Asynchronous reset while the response is pending.
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
        check_eq("rst_mid_outport", outport, RESET_OUT);
        check_eq("rst_mid_rdata", rsp_rdata, 32'h0);
        model_out = RESET_OUT;
        model_in  = 32'h0;
        $display("TXN reset_in_resp outport=%h", outport);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        set_inport(32'h1357_9bdf);
        run_txn("post_rst_out", 1'b0, 32'hfffc, 3'd2, 32'h0, rd);
        run_txn("post_rst_ram", 1'b0, 32'h10, 3'd2, 32'h0, rd);
        run_txn("post_rst_in", 1'b0, 32'hfffa, 3'd5, 32'h0, rd);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side memory responder that terminates the core's load/store requests.
- Decodes LOAD_STORE_FNS funct3 sizes (BYTE/HALF/WORD/BYTE_U/HALF_U).
- Serves an internal word RAM plus two MMIO words: the output port at OUTPORT_ADDR (32'hfffc) and an input port at INPORT_ADDR (32'hfff8).
- Sits between the core's memory stage and the board I/O; uses a valid/ready request and response handshake.

Parameters:
- DEPTH, 1024, number of 32-bit RAM words; RAM occupies byte addresses 0 .. DEPTH*4-1; must be a power of 2 and DEPTH*4 <= 32'hfff8.
- RESET_OUT, 32'h0, reset value of the output port register.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  access size/sign, LOAD_STORE_FNS::funct3_t.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load data, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned, unmapped or illegal-funct3 access.
- inport  in  32  board input, sampled through a 2-flop synchronizer.
- outport  out  32  output port register.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - outport=RESET_OUT; synchronizer flops=0.
  - RAM contents are not reset.
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - A response completes when rsp_valid && rsp_ready.
  - rsp_valid, rsp_rdata and rsp_err hold stable until the response completes.
  - One outstanding request; req_ready=1 only in IDLE.
- FSM IDLE -> RD -> RESP -> IDLE:
  - IDLE, accepted RAM load: issue synchronous RAM read, go to RD.
  - IDLE, accepted store, MMIO load or error: go straight to RESP, with response registered on the accept edge.
  - RD: RAM data returns; extend it and register the response; go to RESP.
  - RESP: rsp_valid=1; on rsp_ready go to IDLE. req_ready becomes 1 the cycle after completion, so there is no same-cycle response/request overlap.
- Latency:
  - RAM load: accept at edge N, rsp_valid from edge N+2.
  - Store, MMIO load, error: rsp_valid from edge N+1.
- Legality (any violation: rsp_err=1, rsp_rdata=0, no state written):
  - HALF/HALF_U require addr[0]=0; WORD requires addr[1:0]=0.
  - Stores allow only BYTE/HALF/WORD; funct3 3'b011, 3'b110, 3'b111 are illegal for all accesses.
  - Mapped addresses: RAM range, OUTPORT_ADDR..+3, INPORT_ADDR..+3; anything else is unmapped.
- Stores:
  - Lane enables derived from funct3 and addr[1:0]: byte = 1 lane, half = lanes {1:0} or {3:2}, word = all.
  - req_wdata is replicated to the selected lanes.
  - RAM write occurs on the accept edge.
  - OUTPORT region: same lane merge into the outport register.
  - Store to the INPORT region: silently ignored, no error, rsp_err=0.
- Loads:
  - Select the lane by addr[1:0].
  - BYTE/HALF sign-extend; BYTE_U/HALF_U zero-extend; WORD passes through.
  - OUTPORT region reads back the outport register; INPORT region reads the synchronized inport.
- Reset mid-operation: FSM returns to IDLE and any pending response is discarded. A store accepted on the same edge that reset asserts is not guaranteed to land.
- Ignored inputs: req_* while req_ready=0; rsp_ready outside RESP.

Decomposition:
- Add to package LOAD_STORE_FNS:
  - INPORT_ADDR = 32'hfff8.
  - typedef enum dmem_state_t {IDLE, RD, RESP}.
  - Function lane_enable(funct3, addr[1:0]) returning logic [3:0].
  - Function load_extend(funct3, addr[1:0], word) returning logic [31:0].
- One sub-module: dmem_ram_be.
  - DEPTH x 32 synchronous-read RAM with 4 byte write enables.
  - Read-during-write to the same address returns old data.

Test Plan:
- Store WORD 32'hdeadbeef @0x10, then load WORD @0x10 -> rsp_rdata=32'hdeadbeef, rsp_err=0, rsp_valid exactly 2 edges after accept.
- Store BYTE 32'h80 @0x13, then load BYTE @0x13 -> 32'hffffff80; load BYTE_U @0x13 -> 32'h00000080; load WORD @0x10 -> 32'h80adbeef.
- Store HALF 32'h1234 @0xfffe, then load WORD @0xfffc -> outport=RESET_OUT[15:0] merged with 32'h1234_0000 in the upper half; rsp_valid 1 edge after accept.
- Hold inport=32'h0000a5a5, wait 3 cycles, load WORD @0xfff8 -> 32'h0000a5a5.
- Errors, each with rsp_err=1, rsp_rdata=0 and no write:
  - load HALF @0x11;
  - store WORD @0x12;
  - load funct3=3'b011;
  - store funct3=BYTE_U;
  - access @0x8000 with DEPTH=1024.
  - Follow-up reads confirm the RAM and outport are unchanged.
- Backpressure/reset: hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout. Then pulse rst_n=0 in RESP -> rsp_valid=0 immediately, req_ready=1, outport=RESET_OUT.
